core_wb_q: RTL and testbench
============================

// Module: core_wb_q
// PURPOSE
//  Parametrised write-back stage between the memory-access (ma) stage and the register/CSR write interface in id.
//  Selects ALU or memory result, aligns and sign-extends sub-word loads, and buffers DEPTH retired results.
//  Exposes a newest-first lookup so id can bypass pending register writes for rs1/rs2.
//  Replaces the single-entry pass-through write-back stage.
// PARAMETERS
//  DEPTH   2   queue entries, >=1
//  XLEN    32  data width; only 32 is supported (elaboration-time assertion)
//  RD_W    5   register index width
//  CSR_W   12  CSR address width
// PORTS
//  clk              in   1      clock, all state updates on rising edge
//  rest             in   1      synchronous active-high reset
//  mw_valid         in   1      ma result valid
//  mw_ready         out  1      stage can accept
//  mw_reg_data      in   XLEN   ALU/address result
//  mw_mem_data      in   XLEN   raw load word, word-aligned
//  mw_mem_funct3    in   3      load type (LB/LH/LW/LBU/LHU)
//  mw_mem_addr_lo   in   2      load address bits [1:0]
//  mw_csr_data      in   XLEN   CSR write value
//  mw_rd            in   RD_W   destination register
//  mw_reg_write     in   1      register write enable
//  mw_reg_write_sel in   1      0 = reg_data, 1 = aligned mem_data
//  mw_csr           in   CSR_W  CSR address
//  mw_csr_write     in   1      CSR write enable
//  wd_valid         out  1      head entry valid
//  wd_ready         in   1      id consumes head
//  wd_reg_data      out  XLEN   final register value
//  wd_rd            out  RD_W
//  wd_reg_write     out  1
//  wd_csr_data      out  XLEN
//  wd_csr           out  CSR_W
//  wd_csr_write     out  1
//  lk_rs1, lk_rs2   in   RD_W   lookup indices from id
//  lk_rs1_hit       out  1      pending write to lk_rs1 exists
//  lk_rs1_data      out  XLEN   value of newest such entry
//  lk_rs2_hit       out  1      pending write to lk_rs2 exists
//  lk_rs2_data      out  XLEN   value of newest such entry
//  wb_count         out  $clog2(DEPTH+1)  occupied entries
// BEHAVIOUR
//  - Reset (rest=1 at edge): count=0, pointers=0, storage cleared. wd_valid=0, all wd_* =0, wb_count=0, lk hits=0.
//  - Accept: mw_valid & mw_ready. mw_ready = (count<DEPTH), registered-state only; no comb path from wd_ready.
//  - Store: value is resolved at enqueue. Reg value = sel ? align(mem_data) : reg_data.
//  - reg_write is forced 0 when rd==0.
//  - An entry whose effective reg_write=0 and csr_write=0 is accepted and discarded; it is not enqueued.
//  - Latency: an entry accepted at edge N is presented on wd_* after edge N (visible in cycle N+1).
//  - Pop: wd_valid & wd_ready. wd_valid = (count!=0); wd_* driven from the head slot.
//  - wd_* hold stable while wd_valid & !wd_ready.
//  - Simultaneous push and pop: count unchanged, both pointers advance; legal when full only if count<DEPTH beforehand.
//  - Pointers wrap modulo DEPTH; DEPTH need not be a power of 2.
//  - Alignment: funct3 000 LB  byte[addr_lo], sign-extended.
//  - Alignment: funct3 100 LBU byte[addr_lo], zero-extended.
//  - Alignment: funct3 001 LH  half[addr_lo[1]], sign-extended. 101 LHU zero-extended. addr_lo[0] is ignored.
//  - Alignment: funct3 010 and all other codes pass the full word.
//  - Lookup (combinational over valid entries, newest first): hit = any valid entry with reg_write & rd==lk_rs. data = newest match.
//  - Lookup for index 0 never hits. The entry being enqueued in the same cycle is not visible.
//  - Reset mid-operation discards all pending entries; no write is emitted.
// STRUCTURE
//  - core_wb_pkg: funct3 load constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
//  - core_wb_pkg: typedef wb_entry_t {reg_data, rd, reg_write, csr_data, csr, csr_write}.
//  - Sub-module core_wb_ldalign: combinational (raw, funct3, addr_lo) -> aligned word.
//  - Top holds the circular buffer, pointers/count and lookup priority logic.
// TESTING
//  - Reset: hold rest 2 cycles with mw_valid=1 -> wd_valid=0, mw_ready=0 during reset; mw_ready=1, wb_count=0 after.
//  - LB: mem_data=0x80FF_7F01, addr_lo=3, funct3=000, sel=1, rd=5 -> wd_reg_data=0xFFFF_FF80, wd_rd=5.
//  - LHU/LH: same word, addr_lo=2 -> LHU gives 0x0000_80FF; LH addr_lo=0 gives 0x0000_7F01.
//  - Backpressure (DEPTH=2): wd_ready=0, push 3 entries -> third stalls, mw_ready=0, wb_count=2, head unchanged.
//  - Backpressure release: wd_ready=1 -> entries drain in order.
//  - Forwarding: pending rd=7 0x11 then rd=7 0x22, lk_rs1=7 -> hit=1, data=0x22. lk_rs2=0 -> hit=0.
//  - Discard: rd=0 with reg_write=1, csr_write=0 -> accepted, wb_count stays 0, wd_valid stays 0.
//  - CSR-only entry: csr_write=1, csr=0x300, csr_data=0x8 -> wd_csr_write=1, wd_reg_write=0.

Source files
------------

// File: rtl/core_wb_pkg.sv
// Shared types and constants for the write-back queue.
// Load funct3 encodings and the queued result entry.
package core_wb_pkg;

    localparam int WB_XLEN  = 32;
    localparam int WB_RD_W  = 5;
    localparam int WB_CSR_W = 12;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [WB_XLEN-1:0]  reg_data;
        logic [WB_RD_W-1:0]  rd;
        logic                reg_write;
        logic [WB_XLEN-1:0]  csr_data;
        logic [WB_CSR_W-1:0] csr;
        logic                csr_write;
    } wb_entry_t;

endpackage

// File: rtl/core_wb_if.sv
// Bundle between ma, the write-back queue and id.
// slave = the queue itself, master = the surrounding pipeline.
interface core_wb_if #(
    parameter int XLEN  = 32,
    parameter int RD_W  = 5,
    parameter int CSR_W = 12,
    parameter int CNT_W = 2
);
    logic             mw_valid;
    logic             mw_ready;
    logic [XLEN-1:0]  mw_reg_data;
    logic [XLEN-1:0]  mw_mem_data;
    logic [2:0]       mw_mem_funct3;
    logic [1:0]       mw_mem_addr_lo;
    logic [XLEN-1:0]  mw_csr_data;
    logic [RD_W-1:0]  mw_rd;
    logic             mw_reg_write;
    logic             mw_reg_write_sel;
    logic [CSR_W-1:0] mw_csr;
    logic             mw_csr_write;

    logic             wd_valid;
    logic             wd_ready;
    logic [XLEN-1:0]  wd_reg_data;
    logic [RD_W-1:0]  wd_rd;
    logic             wd_reg_write;
    logic [XLEN-1:0]  wd_csr_data;
    logic [CSR_W-1:0] wd_csr;
    logic             wd_csr_write;

    logic [RD_W-1:0]  lk_rs1;
    logic [RD_W-1:0]  lk_rs2;
    logic             lk_rs1_hit;
    logic [XLEN-1:0]  lk_rs1_data;
    logic             lk_rs2_hit;
    logic [XLEN-1:0]  lk_rs2_data;

    logic [CNT_W-1:0] wb_count;

    modport slave (
        input  mw_valid, mw_reg_data, mw_mem_data, mw_mem_funct3,
        input  mw_mem_addr_lo, mw_csr_data, mw_rd, mw_reg_write,
        input  mw_reg_write_sel, mw_csr, mw_csr_write,
        output mw_ready,
        output wd_valid, wd_reg_data, wd_rd, wd_reg_write,
        output wd_csr_data, wd_csr, wd_csr_write,
        input  wd_ready,
        input  lk_rs1, lk_rs2,
        output lk_rs1_hit, lk_rs1_data, lk_rs2_hit, lk_rs2_data,
        output wb_count
    );

    modport master (
        output mw_valid, mw_reg_data, mw_mem_data, mw_mem_funct3,
        output mw_mem_addr_lo, mw_csr_data, mw_rd, mw_reg_write,
        output mw_reg_write_sel, mw_csr, mw_csr_write,
        input  mw_ready,
        input  wd_valid, wd_reg_data, wd_rd, wd_reg_write,
        input  wd_csr_data, wd_csr, wd_csr_write,
        output wd_ready,
        output lk_rs1, lk_rs2,
        input  lk_rs1_hit, lk_rs1_data, lk_rs2_hit, lk_rs2_data,
        input  wb_count
    );

endinterface

// File: rtl/core_wb_ldalign.sv
// Load alignment: picks the addressed byte/half of a word-aligned
// load and sign- or zero-extends it.
module core_wb_ldalign
    import core_wb_pkg::*;
(
    input  logic [WB_XLEN-1:0] raw_i,
    input  logic [2:0]         funct3_i,
    input  logic [1:0]         addr_lo_i,
    output logic [WB_XLEN-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'(raw_i >> {addr_lo_i, 3'b000});
        half_sel = addr_lo_i[1] ? raw_i[31:16] : raw_i[15:0];
        case (funct3_i)
            F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data_o = {24'h0, byte_sel};
            F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data_o = {16'h0, half_sel};
            F3_LW:   data_o = raw_i;
            default: data_o = raw_i;
        endcase
    end

endmodule

// File: rtl/core_wb_q.sv
// Write-back queue: resolves results at enqueue, buffers DEPTH of
// them for id, and offers newest-first bypass lookup on rs1/rs2.
module core_wb_q
    import core_wb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32,
    parameter int RD_W  = 5,
    parameter int CSR_W = 12
) (
    input  logic     clk,
    input  logic     rest,
    core_wb_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    generate
        if (XLEN != 32) begin : g_xlen_chk
            $error("core_wb_q: only XLEN=32 is supported");
        end
        if (RD_W != WB_RD_W || CSR_W != WB_CSR_W) begin : g_w_chk
            $error("core_wb_q: RD_W/CSR_W must match core_wb_pkg");
        end
        if (DEPTH < 1) begin : g_d_chk
            $error("core_wb_q: DEPTH must be >= 1");
        end
    endgenerate

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];

    logic [XLEN-1:0]  ld_data;
    wb_entry_t        new_e;
    wb_entry_t        head_e;
    logic             eff_we;
    logic             push;
    logic             pop;

    core_wb_ldalign u_ldalign (
        .raw_i     (bus.mw_mem_data),
        .funct3_i  (bus.mw_mem_funct3),
        .addr_lo_i (bus.mw_mem_addr_lo),
        .data_o    (ld_data)
    );

    // Ready depends only on state (and reset), never on wd_ready.
    assign bus.mw_ready = !rest && (count_q < FULL);
    assign bus.wd_valid = (count_q != '0);
    assign bus.wb_count = count_q;

    always_comb begin
        eff_we = bus.mw_reg_write && (bus.mw_rd != '0);
        new_e.reg_data  = bus.mw_reg_write_sel ? ld_data
                                               : bus.mw_reg_data;
        new_e.rd        = bus.mw_rd;
        new_e.reg_write = eff_we;
        new_e.csr_data  = bus.mw_csr_data;
        new_e.csr       = bus.mw_csr;
        new_e.csr_write = bus.mw_csr_write;
        push = bus.mw_valid && bus.mw_ready
            && (eff_we || bus.mw_csr_write);
        pop  = bus.wd_valid && bus.wd_ready;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = new_e;
            wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    always_comb begin
        head_e = mem_q[rd_ptr_q];
        if (!bus.wd_valid) begin
            head_e = '0;
        end
        bus.wd_reg_data  = head_e.reg_data;
        bus.wd_rd        = head_e.rd;
        bus.wd_reg_write = head_e.reg_write;
        bus.wd_csr_data  = head_e.csr_data;
        bus.wd_csr       = head_e.csr;
        bus.wd_csr_write = head_e.csr_write;
    end

    // Walk oldest to newest so the newest match wins.
    always_comb begin : lookup
        int idx;
        idx = 0;
        bus.lk_rs1_hit  = 1'b0;
        bus.lk_rs1_data = '0;
        bus.lk_rs2_hit  = 1'b0;
        bus.lk_rs2_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = int'(rd_ptr_q) + i;
            if (idx >= DEPTH) begin
                idx = idx - DEPTH;
            end
            if (CNT_W'(i) < count_q && mem_q[PTR_W'(idx)].reg_write) begin
                if (bus.lk_rs1 != '0
                    && mem_q[PTR_W'(idx)].rd == bus.lk_rs1) begin
                    bus.lk_rs1_hit  = 1'b1;
                    bus.lk_rs1_data = mem_q[PTR_W'(idx)].reg_data;
                end
                if (bus.lk_rs2 != '0
                    && mem_q[PTR_W'(idx)].rd == bus.lk_rs2) begin
                    bus.lk_rs2_hit  = 1'b1;
                    bus.lk_rs2_data = mem_q[PTR_W'(idx)].reg_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_core_wb_q.sv
// Directed bench for core_wb_q with DEPTH=2.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_core_wb_q;

    logic clk;
    logic rest;
    int   n_tests;
    int   n_fail;

    core_wb_if #(.XLEN(32), .RD_W(5), .CSR_W(12), .CNT_W(2)) bus ();

    core_wb_q #(.DEPTH(2), .XLEN(32), .RD_W(5), .CSR_W(12)) dut (
        .clk  (clk),
        .rest (rest),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] rdata,
                         input logic [31:0] mdata, input logic [2:0] f3,
                         input logic [1:0] alo, input logic sel,
                         input logic [4:0] rd, input logic we,
                         input logic [31:0] cdata, input logic [11:0] csr,
                         input logic cwe);
        bus.mw_valid         = v;
        bus.mw_reg_data      = rdata;
        bus.mw_mem_data      = mdata;
        bus.mw_mem_funct3    = f3;
        bus.mw_mem_addr_lo   = alo;
        bus.mw_reg_write_sel = sel;
        bus.mw_rd            = rd;
        bus.mw_reg_write     = we;
        bus.mw_csr_data      = cdata;
        bus.mw_csr           = csr;
        bus.mw_csr_write     = cwe;
    endtask

    task automatic one_load(input string tag, input logic [2:0] f3,
                            input logic [1:0] alo, input logic [31:0] exp);
        drive(1, 32'h0, 32'h80FF_7F01, f3, alo, 1, 5'd5, 1, 0, 0, 0);
        tick();
        bus.mw_valid = 1'b0;
        chk({tag, "_data"}, bus.wd_reg_data, exp);
        bus.wd_ready = 1'b1;
        tick();
        bus.wd_ready = 1'b0;
        chk({tag, "_drain"}, 32'(bus.wb_count), 32'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rest = 1'b1;
        bus.wd_ready = 1'b0;
        bus.lk_rs1 = 5'd3;
        bus.lk_rs2 = 5'd0;
        drive(1, 32'h1234, 0, 3'b010, 0, 0, 5'd3, 1, 0, 0, 0);

        // reset held two cycles with valid input
        tick();
        chk("rst_wd_valid0", 32'(bus.wd_valid), 0);
        chk("rst_ready0", 32'(bus.mw_ready), 0);
        tick();
        chk("rst_wd_valid1", 32'(bus.wd_valid), 0);
        chk("rst_ready1", 32'(bus.mw_ready), 0);
        chk("rst_wd_data", bus.wd_reg_data, 0);
        rest = 1'b0;
        bus.mw_valid = 1'b0;
        #1;
        chk("post_rst_ready", 32'(bus.mw_ready), 1);
        chk("post_rst_count", 32'(bus.wb_count), 0);
        chk("post_rst_hit", 32'(bus.lk_rs1_hit), 0);

        // LB from byte 3 of 0x80FF7F01
        drive(1, 0, 32'h80FF_7F01, 3'b000, 2'd3, 1, 5'd5, 1, 0, 0, 0);
        tick();
        bus.mw_valid = 1'b0;
        chk("lb_valid", 32'(bus.wd_valid), 1);
        chk("lb_data", bus.wd_reg_data, 32'hFFFF_FF80);
        chk("lb_rd", 32'(bus.wd_rd), 5);
        chk("lb_we", 32'(bus.wd_reg_write), 1);
        chk("lb_count", 32'(bus.wb_count), 1);
        bus.wd_ready = 1'b1;
        tick();
        bus.wd_ready = 1'b0;
        chk("lb_drain", 32'(bus.wb_count), 0);

        one_load("lhu2", 3'b101, 2'd2, 32'h0000_80FF);
        one_load("lh0", 3'b001, 2'd0, 32'h0000_7F01);
        one_load("lh2", 3'b001, 2'd3, 32'hFFFF_80FF);
        one_load("lbu2", 3'b100, 2'd2, 32'h0000_00FF);
        one_load("lb1", 3'b000, 2'd1, 32'h0000_007F);
        one_load("lw", 3'b010, 2'd1, 32'h80FF_7F01);
        one_load("f3_111", 3'b111, 2'd0, 32'h80FF_7F01);

        // backpressure: three pushes into a 2-deep queue
        drive(1, 32'hA1, 32'hFFFF_FFFF, 3'b000, 0, 0, 5'd1, 1, 0, 0, 0);
        tick();
        drive(1, 32'hB2, 0, 3'b000, 0, 0, 5'd2, 1, 0, 0, 0);
        tick();
        drive(1, 32'hC3, 0, 3'b000, 0, 0, 5'd3, 1, 0, 0, 0);
        tick();
        chk("bp_ready", 32'(bus.mw_ready), 0);
        chk("bp_count", 32'(bus.wb_count), 2);
        chk("bp_head", bus.wd_reg_data, 32'hA1);
        tick();
        chk("bp_hold_head", bus.wd_reg_data, 32'hA1);
        chk("bp_hold_rd", 32'(bus.wd_rd), 1);
        bus.wd_ready = 1'b1;
        tick();
        chk("bp_pop1_count", 32'(bus.wb_count), 1);
        chk("bp_pop1_head", bus.wd_reg_data, 32'hB2);
        tick();
        chk("bp_pushpop_count", 32'(bus.wb_count), 1);
        chk("bp_pushpop_head", bus.wd_reg_data, 32'hC3);
        bus.mw_valid = 1'b0;
        tick();
        chk("bp_empty", 32'(bus.wd_valid), 0);
        bus.wd_ready = 1'b0;

        // forwarding, newest first, same-cycle enqueue invisible
        bus.lk_rs1 = 5'd7;
        bus.lk_rs2 = 5'd0;
        drive(1, 32'h11, 0, 3'b000, 0, 0, 5'd7, 1, 0, 0, 0);
        #1;
        chk("fw_pre_hit", 32'(bus.lk_rs1_hit), 0);
        tick();
        drive(1, 32'h22, 0, 3'b000, 0, 0, 5'd7, 1, 0, 0, 0);
        #1;
        chk("fw_one_data", bus.lk_rs1_data, 32'h11);
        tick();
        bus.mw_valid = 1'b0;
        #1;
        chk("fw_hit", 32'(bus.lk_rs1_hit), 1);
        chk("fw_data", bus.lk_rs1_data, 32'h22);
        chk("fw_rs2_zero", 32'(bus.lk_rs2_hit), 0);
        bus.lk_rs2 = 5'd8;
        #1;
        chk("fw_rs2_miss", 32'(bus.lk_rs2_hit), 0);
        bus.wd_ready = 1'b1;
        tick();
        chk("fw_after_pop", bus.lk_rs1_data, 32'h22);
        tick();
        bus.wd_ready = 1'b0;
        chk("fw_drained_hit", 32'(bus.lk_rs1_hit), 0);

        // discard of a write to x0
        drive(1, 32'hDEAD, 0, 3'b000, 0, 0, 5'd0, 1, 0, 0, 0);
        tick();
        bus.mw_valid = 1'b0;
        chk("disc_count", 32'(bus.wb_count), 0);
        chk("disc_valid", 32'(bus.wd_valid), 0);

        // CSR-only entry
        drive(1, 32'h55, 0, 3'b000, 0, 0, 5'd9, 0, 32'h8, 12'h300, 1);
        tick();
        bus.mw_valid = 1'b0;
        bus.lk_rs1 = 5'd9;
        #1;
        chk("csr_valid", 32'(bus.wd_valid), 1);
        chk("csr_we", 32'(bus.wd_csr_write), 1);
        chk("csr_reg_we", 32'(bus.wd_reg_write), 0);
        chk("csr_addr", 32'(bus.wd_csr), 32'h300);
        chk("csr_data", bus.wd_csr_data, 32'h8);
        chk("csr_no_fwd", 32'(bus.lk_rs1_hit), 0);

        // reset with pending entries
        drive(1, 32'h77, 0, 3'b000, 0, 0, 5'd9, 1, 0, 0, 0);
        tick();
        chk("mid_count", 32'(bus.wb_count), 2);
        bus.mw_valid = 1'b0;
        rest = 1'b1;
        tick();
        rest = 1'b0;
        #1;
        chk("mid_rst_count", 32'(bus.wb_count), 0);
        chk("mid_rst_valid", 32'(bus.wd_valid), 0);
        chk("mid_rst_csr_we", 32'(bus.wd_csr_write), 0);
        chk("mid_rst_hit", 32'(bus.lk_rs1_hit), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
